// File: rtl/copro_reconfig_req.sv
// copro_reconfig_req: request front-end for the ICAP MultiBoot sequencer.
// Arbitrates a host selection write against a debounced button press,
// holds design_num/powerup stable, then issues a timed reconfigure pulse.
// Optional feature macro: COPRO_BUTTON_EN (button sync + debounce path).
// Ports:
//   fastclk      sole clock
//   rst_n        async active-low reset
//   wr_en        host write strobe
//   wr_data      [7]=commit, [4:0]=design number
//   btn_n        raw active-low button (async)
//   initialized  sequencer idle/ready
//   design_num   selected design (reset 5'b01110)
//   powerup      1 = switch-driven boot (button request)
//   reconfigure  request pulse to the sequencer
//   busy         FSM not in IDLE
//   err          sticky timeout flag, cleared by next host commit
module copro_reconfig_req #(
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned SETUP_CYCLES    = 4,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       fastclk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       btn_n,
    input  logic       initialized,
    output logic [4:0] design_num,
    output logic       powerup,
    output logic       reconfigure,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        ARM,
        PULSE,
        DONE
    } state_t;

    localparam logic [4:0]  DN_RST    = 5'b01110;
    localparam logic [15:0] SETUP_LST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] PULSE_LST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] TO_LST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [4:0]  pend;
    logic        idle;
    logic        host_req;
    logic        btn_req;
    logic        btn_fall;
    logic        timeout;

    assign idle     = (state == IDLE);
    assign busy     = !idle;
    assign host_req = idle && wr_en && wr_data[7];
    // Host commit wins a same-cycle tie; the button event is lost.
    assign btn_req  = idle && btn_fall && !host_req;
    assign timeout  = (state == DONE) && initialized && (cnt == TO_LST);

`ifdef COPRO_BUTTON_EN
    localparam logic [15:0] DB_LST = 16'(DEBOUNCE_CYCLES - 1);

    logic        btn_s1, btn_s2, btn_s3;
    logic        btn_db;
    logic [15:0] db_cnt;

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            btn_s3 <= 1'b1;
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            // Any change of the synchronised level restarts the window;
            // the counter then saturates at its terminal value.
            if (btn_s2 != btn_s3) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_LST) begin
                db_cnt <= db_cnt + 16'd1;
            end
            if (db_cnt == DB_LST) begin
                btn_db <= btn_s3;
            end
        end
    end

    assign btn_fall = (db_cnt == DB_LST) && btn_db && !btn_s3;
`else
    logic unused_btn;
    assign unused_btn = btn_n;
    assign btn_fall   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (host_req || btn_req) begin
                    state_nx = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (initialized) begin
                    state_nx = ARM;
                    cnt_nx   = '0;
                end
            end
            ARM: begin
                if (cnt == SETUP_LST) begin
                    state_nx = PULSE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LST) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            DONE: begin
                if (!initialized || timeout) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pend        <= DN_RST;
            design_num  <= DN_RST;
            powerup     <= 1'b0;
            reconfigure <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (idle && wr_en) begin
                pend <= wr_data[4:0];
            end
            if (host_req) begin
                design_num <= wr_data[4:0];
                powerup    <= 1'b0;
            end else if (btn_req) begin
                design_num <= pend;
                powerup    <= 1'b1;
            end
            // Registered so the sequencer never sees a decode glitch.
            reconfigure <= (state == PULSE);
            if (timeout) begin
                err <= 1'b1;
            end else if (host_req) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_copro_reconfig_req.sv
// tb_copro_reconfig_req: directed + randomized bench for copro_reconfig_req.
// Expected timing comes from a cycle-count model of the request sequence.
module tb_copro_reconfig_req;

    localparam int DEB = 64;

    logic       fastclk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       btn_n;
    logic       initialized;
    logic [4:0] design_num;
    logic       powerup;
    logic       reconfigure;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [4:0] dn_m;
    logic       pu_m;
    logic [4:0] pend_m;
    logic       err_m;

    copro_reconfig_req #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .fastclk    (fastclk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .btn_n      (btn_n),
        .initialized(initialized),
        .design_num (design_num),
        .powerup    (powerup),
        .reconfigure(reconfigure),
        .busy       (busy),
        .err        (err)
    );

    initial fastclk = 1'b0;
    always #5 fastclk = ~fastclk;

    task automatic tick();
        @(posedge fastclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs from the cycle after an accepted request. initialized is
    // first sampled high on edge k (relative to the accepting edge);
    // the pulse then occupies edges k+5..k+8. Without a timeout the
    // sequencer drops initialized for edge k+9; with one, DONE spans
    // TIMEOUT_CYCLES (1024) cycles and err appears on edge k+1032.
    // A write is injected at edge inj+1 while busy and must be dropped.
    task automatic seq(input int k, input bit to, input logic [4:0] dn,
                       input logic pu, input int inj);
        int last;
        last = to ? k + 1031 : k + 8;
        initialized = (k <= 1);
        for (int n = 1; n <= last + 2; n++) begin
            tick();
            wr_en = 1'b0;
            chk("reconfigure", reconfigure, (n >= k + 5) && (n <= k + 8));
            chk("busy", busy, n <= last);
            chk("err", err, err_m | (to && n >= k + 1032));
            chk("design_num", design_num, dn);
            chk("powerup", powerup, pu);
            if (n == inj) begin
                wr_en   = 1'b1;
                wr_data = 8'h80 | 8'($urandom_range(0, 31));
            end
            initialized = (n + 1 >= k) && (to || n + 1 <= k + 8);
        end
        if (to) err_m = 1'b1;
    endtask

    task automatic host(input logic [7:0] data, input int k, input bit to,
                        input int inj);
        initialized = 1'b0;
        wr_en   = 1'b1;
        wr_data = data;
        tick();
        wr_en  = 1'b0;
        pend_m = data[4:0];
        if (data[7]) begin
            dn_m  = data[4:0];
            pu_m  = 1'b0;
            err_m = 1'b0;
            chk("accept_busy", busy, 1'b1);
            chk("accept_dn", design_num, dn_m);
            chk("accept_err", err, err_m);
            seq(k, to, dn_m, pu_m, inj);
        end else begin
            repeat (3) begin
                tick();
                chk("nocommit_busy", busy, 1'b0);
                chk("nocommit_dn", design_num, dn_m);
            end
        end
    endtask

    initial begin
        logic [4:0] d;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        btn_n       = 1'b1;
        initialized = 1'b0;
        dn_m        = 5'b01110;
        pu_m        = 1'b0;
        pend_m      = 5'b01110;
        err_m       = 1'b0;

        #12;
        chk("rst_dn", design_num, 5'b01110);
        chk("rst_pu", powerup, 1'b0);
        chk("rst_reconf", reconfigure, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        #10;
        rst_n = 1'b1;
        tick();

        host(8'h85, 1, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            host(8'h80 | 8'($urandom_range(0, 31)),
                 int'($urandom_range(1, 4)), 1'b0, 0);
            host(8'($urandom_range(0, 127)), 1, 1'b0, 0);
        end

        // initialized held low, then raised; write during busy ignored
        host(8'h80 | 8'($urandom_range(0, 31)), 7, 1'b0, 3);

        // timeout in DONE, then next commit clears err
        host(8'h9A, 1, 1'b1, 0);
        host(8'h80 | 8'($urandom_range(0, 31)), 2, 1'b0, 0);

`ifdef COPRO_BUTTON_EN
        host(8'h03, 1, 1'b0, 0);
        btn_n = 1'b0;
        for (int i = 1; i <= DEB + 2; i++) begin
            tick();
            if (i == DEB + 2) chk("btn_early", busy, 1'b0);
        end
        tick();
        dn_m = pend_m;
        pu_m = 1'b1;
        chk("btn_busy", busy, 1'b1);
        chk("btn_dn", design_num, 5'd3);
        chk("btn_pu", powerup, 1'b1);
        seq(1, 1'b0, dn_m, pu_m, 0);
        btn_n = 1'b1;
        repeat (DEB + 8) tick();
        chk("btn_release", busy, 1'b0);

        host(8'h0B, 1, 1'b0, 0);
        btn_n = 1'b0;
        repeat (DEB + 2) tick();
        d       = 5'($urandom_range(0, 31));
        wr_en   = 1'b1;
        wr_data = {3'b100, d};
        tick();
        wr_en  = 1'b0;
        dn_m   = d;
        pu_m   = 1'b0;
        pend_m = d;
        err_m  = 1'b0;
        chk("tie_dn", design_num, d);
        chk("tie_pu", powerup, 1'b0);
        seq(2, 1'b0, dn_m, pu_m, 3);
        btn_n = 1'b1;
        repeat (DEB + 8) tick();
        chk("tie_after", busy, 1'b0);
`else
        btn_n = 1'b0;
        repeat (DEB + 8) tick();
        chk("nobtn_busy", busy, 1'b0);
        chk("nobtn_pu", powerup, 1'b0);
        btn_n = 1'b1;
        repeat (4) tick();
`endif

        // reset in the middle of the pulse
        wr_en   = 1'b1;
        wr_data = 8'h91;
        tick();
        wr_en       = 1'b0;
        initialized = 1'b1;
        repeat (7) tick();
        chk("pre_rst_reconf", reconfigure, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reconf", reconfigure, 1'b0);
        chk("async_dn", design_num, 5'b01110);
        chk("async_busy", busy, 1'b0);
        chk("async_pu", powerup, 1'b0);
        #3;
        rst_n       = 1'b1;
        initialized = 1'b0;
        tick();
        chk("post_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/copro_reconfig_req.md
# copro_reconfig_req

Request front-end for the ICAP MultiBoot sequencer. It accepts a host-side coprocessor selection write or a debounced front-panel button press and arbitrates between them. It then presents a stable `design_num`/`powerup` pair and issues a timed `reconfigure` pulse, only once the sequencer reports `initialized`. Runs on `fastclk`, so the pulse must span several sequencer (half-rate) clocks.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 65535: stable-level cycles required before a button edge is accepted (counter width 16).
- `SETUP_CYCLES`, 4: cycles `design_num`/`powerup` are held stable before `reconfigure` rises.
- `PULSE_CYCLES`, 4: width of the `reconfigure` high pulse, in `fastclk` cycles (minimum 2).
- `TIMEOUT_CYCLES`, 1024: cycles to wait in `DONE` for `initialized` to fall before declaring failure.

Ports:
- `fastclk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: single-cycle host write strobe.
- `wr_data` in 8: `[7]` = commit, `[4:0]` = design number.
- `btn_n` in 1: raw front-panel button, active-low, asynchronous to `fastclk`.
- `initialized` in 1: sequencer idle/ready.
- `design_num` out 5: selected design; reset value 5'b01110.
- `powerup` out 1: 1 selects switch-driven boot; reset value 0.
- `reconfigure` out 1: request pulse; reset value 0.
- `busy` out 1: high in any state other than `IDLE`; reset value 0.
- `err` out 1: sticky timeout flag; reset value 0.

## Operation

- **Pending register:**
  - Any `wr_en` in `IDLE` latches `wr_data[4:0]` into `pend`.
  - If `wr_data[7]=1`, a host request is also raised, with `powerup` set to 0.
  - `wr_en` outside `IDLE` is dropped entirely; `pend` is unchanged.
- **Button path:**
  - `btn_n` passes through a 2-flop synchroniser, then a debounce counter.
  - The counter reloads on any change of the synchronised level.
  - The debounced level updates when the counter reaches `DEBOUNCE_CYCLES-1`.
  - A debounced high-to-low transition seen in `IDLE` raises a button request, with `powerup` set to 1 and `design_num` set to `pend`.
- **Arbitration:** a host commit and a button request in the same cycle → the host request wins; the button event is discarded.
- **FSM states:**
  - `IDLE`: on a request, load the outputs → `WAIT_INIT`.
  - `WAIT_INIT`: hold until `initialized=1` → `ARM`, with the counter cleared.
  - `ARM`: count `SETUP_CYCLES` → `PULSE`.
  - `PULSE`: `reconfigure=1` for `PULSE_CYCLES` → `DONE`.
  - `DONE`: `initialized=0` → `IDLE` (the sequencer took the request); counter reaching `TIMEOUT_CYCLES` → set `err`, then `IDLE`.
- `err` clears on the next accepted host commit.
- `design_num` and `powerup` change only on the `IDLE` → `WAIT_INIT` transition and are held through `DONE`.

## Timing

- The request is registered; `busy` and the outputs update in the cycle after the `wr_en` edge.
- `WAIT_INIT` with `initialized` already high lasts 1 cycle.
- `reconfigure` therefore rises `1 + 1 + SETUP_CYCLES` cycles after the accepting edge (6 with defaults).
- `reconfigure` falls exactly `PULSE_CYCLES` later.
- Button latency: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1.
- Counters saturate; they never wrap.
- Reset asserted mid-sequence drops `reconfigure` immediately (asynchronous) and returns all outputs to their reset values.

## Configuration

- `COPRO_BUTTON_EN` defined: the button synchroniser, debounce counter and button request are compiled in.
- Not defined: `btn_n` is ignored, no debounce logic is generated, and `powerup` is constant 0.

## Test plan

- Reset, then `wr_en=1`, `wr_data=8'h85`, `initialized=1` → `design_num=5'h05`, `powerup=0`, `reconfigure` high on cycles 6–9 after the edge; `initialized` then dropped → `busy=0`.
- `wr_data=8'h03` (commit 0) → `pend=3`, no `busy`. Then a button press held 70000 cycles → `powerup=1`, `design_num=3`, pulse issued.
- `initialized=0` held, then host commit → FSM stays in `WAIT_INIT`, `reconfigure=0`. Raising `initialized` → pulse 5 cycles later.
- Pulse issued, `initialized` held at 1 → `err=1` after 1024 cycles in `DONE`, then `IDLE`. A next commit clears `err`.
- Host commit and debounced press in the same cycle → `powerup=0`, host `design_num`. A `wr_en` during `busy` → ignored.
- `rst_n` low during `PULSE` → `reconfigure=0` without a clock edge, `design_num=5'b01110`.
